// File: rtl/ysyx_24070016_lsu.sv
// Load/store stage: one memory access in flight, valid/ready on input, memory and write-back sides.
// Optional YSYX_24070016_LSU_MISALIGN_TRAP_EN: misaligned h/w accesses fault instead of being force-aligned.
module ysyx_24070016_lsu #(
  parameter int TIMEOUT_CYC = 255,
  parameter int RD_W        = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_result,
  input  logic [31:0]     in_wdata,
  input  logic [2:0]      in_funct3,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_rd_wen,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [31:0]     mem_req_addr,
  output logic            mem_req_wen,
  output logic [31:0]     mem_req_wdata,
  output logic [3:0]      mem_req_wmask,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wen,
  output logic            out_err
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;
  logic              is_load_q, is_load_d;
  logic              rd_wen_q, rd_wen_d;
  logic              in_ready_q, in_ready_d;
  logic              req_valid_q, req_valid_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic              req_wen_q, req_wen_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [3:0]        req_wmask_q, req_wmask_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_result_q, out_result_d;
  logic [RD_W-1:0]   out_rd_q, out_rd_d;
  logic              out_wen_q, out_wen_d;
  logic              out_err_q, out_err_d;

  logic        mem_op, is_store, illegal, mis_err, tmo_hit;
  logic [31:0] eff_addr, wdata_lane, rsp_shift, load_val;
  logic [1:0]  lane;
  logic [3:0]  wmask;

  always_comb begin
    mem_op   = in_is_load || in_is_store;
    is_store = in_is_store && !in_is_load;
    case (in_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = is_store;
      default:                illegal = 1'b1;
    endcase
    // Force-align h/w addresses; in the trap build a misaligned op never reaches memory anyway.
    eff_addr = in_result;
    if (in_funct3[1:0] == 2'b01)      eff_addr[0]   = 1'b0;
    else if (in_funct3[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
`ifdef YSYX_24070016_LSU_MISALIGN_TRAP_EN
    mis_err = (in_funct3[1:0] == 2'b01 && in_result[0]) ||
              (in_funct3[1:0] == 2'b10 && in_result[1:0] != 2'b00);
`else
    mis_err = 1'b0;
`endif
    lane = eff_addr[1:0];
    case (in_funct3[1:0])
      2'b00:   begin wmask = 4'b0001 << lane;             wdata_lane = {4{in_wdata[7:0]}};  end
      2'b01:   begin wmask = 4'b0011 << {lane[1], 1'b0};  wdata_lane = {2{in_wdata[15:0]}}; end
      default: begin wmask = 4'b1111;                     wdata_lane = in_wdata;            end
    endcase
    rsp_shift = mem_rsp_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{rsp_shift[7]}}, rsp_shift[7:0]};
      3'b001:  load_val = {{16{rsp_shift[15]}}, rsp_shift[15:0]};
      3'b100:  load_val = {24'd0, rsp_shift[7:0]};
      3'b101:  load_val = {16'd0, rsp_shift[15:0]};
      default: load_val = rsp_shift;
    endcase
    tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  end

  always_comb begin
    state_d      = state_q;      cnt_d        = cnt_q;
    funct3_d     = funct3_q;     lane_d       = lane_q;
    is_load_d    = is_load_q;    rd_wen_d     = rd_wen_q;
    in_ready_d   = in_ready_q;   req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;   req_wen_d    = req_wen_q;
    req_wdata_d  = req_wdata_q;  req_wmask_d  = req_wmask_q;
    out_valid_d  = out_valid_q;  out_result_d = out_result_q;
    out_rd_d     = out_rd_q;     out_wen_d    = out_wen_q;
    out_err_d    = out_err_q;
    case (state_q)
      S_IDLE: if (in_valid && in_ready_q) begin
        in_ready_d = 1'b0;
        funct3_d   = in_funct3;
        lane_d     = lane;
        is_load_d  = in_is_load;
        rd_wen_d   = in_rd_wen;
        out_rd_d   = in_rd;
        if (!mem_op) begin
          state_d = S_DONE; out_valid_d = 1'b1;
          out_result_d = in_result; out_wen_d = in_rd_wen; out_err_d = 1'b0;
        end else if (illegal || mis_err) begin
          state_d = S_DONE; out_valid_d = 1'b1;
          out_result_d = 32'd0; out_wen_d = 1'b0; out_err_d = 1'b1;
        end else begin
          state_d     = S_REQ;
          req_valid_d = 1'b1;
          req_addr_d  = {eff_addr[31:2], 2'b00};
          req_wen_d   = is_store;
          req_wmask_d = is_store ? wmask : 4'b0000;
          req_wdata_d = is_store ? wdata_lane : 32'd0;
        end
      end
      S_REQ: if (mem_req_ready) begin
        state_d = S_WAIT; req_valid_d = 1'b0; cnt_d = '0;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = S_DONE; out_valid_d = 1'b1; out_err_d = 1'b0;
          out_result_d = is_load_q ? load_val : 32'd0;
          out_wen_d    = is_load_q && rd_wen_q;
        end else if (tmo_hit) begin
          state_d = S_DONE; out_valid_d = 1'b1;
          out_result_d = 32'd0; out_wen_d = 1'b0; out_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: if (out_ready) begin
        state_d = S_IDLE; out_valid_d = 1'b0; in_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  cnt_q <= '0;  funct3_q <= '0;  lane_q <= '0;
      is_load_q <= 1'b0;  rd_wen_q <= 1'b0;  in_ready_q <= 1'b1;
      req_valid_q <= 1'b0;  req_addr_q <= '0;  req_wen_q <= 1'b0;
      req_wdata_q <= '0;  req_wmask_q <= '0;
      out_valid_q <= 1'b0;  out_result_q <= '0;  out_rd_q <= '0;
      out_wen_q <= 1'b0;  out_err_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  funct3_q <= funct3_d;  lane_q <= lane_d;
      is_load_q <= is_load_d;  rd_wen_q <= rd_wen_d;  in_ready_q <= in_ready_d;
      req_valid_q <= req_valid_d;  req_addr_q <= req_addr_d;  req_wen_q <= req_wen_d;
      req_wdata_q <= req_wdata_d;  req_wmask_q <= req_wmask_d;
      out_valid_q <= out_valid_d;  out_result_q <= out_result_d;  out_rd_q <= out_rd_d;
      out_wen_q <= out_wen_d;  out_err_q <= out_err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_rd        = out_rd_q;
  assign out_wen       = out_wen_q;
  assign out_err       = out_err_q;
endmodule

// File: tb/tb_ysyx_24070016_lsu.sv
// Randomized bench for ysyx_24070016_lsu: directed cases plus random ops against a behavioural model.
module tb_ysyx_24070016_lsu;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_load, in_is_store, in_rd_wen;
  logic [31:0] in_result, in_wdata;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, out_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata, out_result;
  logic [3:0]  mem_req_wmask;
  logic        out_valid, out_ready, out_wen, out_err;

  always #5 clk = ~clk;

  ysyx_24070016_lsu #(.TIMEOUT_CYC(TMO), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_wdata(in_wdata),
    .in_funct3(in_funct3), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen), .out_err(out_err)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One instruction end to end; the bench plays the memory with the given delays.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input logic [4:0] rd,
                        input bit rwen, input int req_dly, input int rsp_dly, input int out_dly);
    int sz, lane, waited;
    bit mem, store, legal, mis, err, tout;
    logic [31:0] eff, e_addr, e_mask, e_wdata, e_res, v;
    logic e_wen, e_err;
    sz    = int'(f3[1:0]);
    mem   = ld || st;
    store = st && !ld;
    legal = store ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    mis   = (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0);
`ifdef YSYX_24070016_LSU_MISALIGN_TRAP_EN
    err = mem && (!legal || mis);
`else
    err = mem && !legal;
`endif
    eff    = (sz == 1) ? addr - addr % 2 : (sz == 2) ? addr - addr % 4 : addr;
    lane   = int'(eff % 4);
    e_addr = eff - eff % 4;
    e_mask  = !store ? 0 : (sz == 0) ? (32'd1 << lane) : (sz == 1) ? (32'd3 << lane) : 32'd15;
    e_wdata = !store ? 0 : (sz == 0) ? wd % 256 * 32'h01010101
                         : (sz == 1) ? wd % 65536 * 32'h00010001 : wd;
    v = rdata >> (8 * lane);
    case (f3)
      3'd0: e_res = (v % 256 >= 128) ? v % 256 + 32'hFFFFFF00 : v % 256;
      3'd1: e_res = (v % 65536 >= 32768) ? v % 65536 + 32'hFFFF0000 : v % 65536;
      3'd4: e_res = v % 256;
      3'd5: e_res = v % 65536;
      default: e_res = rdata;
    endcase
    tout = mem && !err && rsp_dly >= TMO;
    if (!mem)              begin e_res = addr; e_wen = rwen; e_err = 0; end
    else if (err || tout)  begin e_res = 0;    e_wen = 0;    e_err = 1; end
    else if (store)        begin e_res = 0;    e_wen = 0;    e_err = 0; end
    else                   begin               e_wen = rwen; e_err = 0; end
    if (tout && out_dly < 1) out_dly = 1;

    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_result = addr; in_wdata = wd; in_rd = rd; in_rd_wen = rwen;
    @(negedge clk);
    in_valid = 0; in_wdata = $urandom; in_result = $urandom;
    if (mem && !err) begin
      for (int i = 0; i <= req_dly; i++) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr",  mem_req_addr, e_addr);
        chk("req_wen",   mem_req_wen, store);
        chk("req_wmask", mem_req_wmask, e_mask);
        if (store) chk("req_wdata", mem_req_wdata, e_wdata);
        chk("in_ready_busy", in_ready, 0);
        mem_req_ready = (i == req_dly);
        @(negedge clk);
      end
      mem_req_ready = 0;
      chk("req_drop", mem_req_valid, 0);
      if (!tout) begin
        for (int j = 0; j < rsp_dly; j++) @(negedge clk);
        chk("no_early_out", out_valid, 0);
        mem_rsp_valid = 1; mem_rsp_rdata = rdata;
        @(negedge clk);
        mem_rsp_valid = 0; mem_rsp_rdata = $urandom;
      end else begin
        waited = 0;
        while (!out_valid && waited < 40) begin
          @(negedge clk);
          waited++;
        end
        chk("timeout_cycles", waited, TMO);
      end
    end else begin
      chk("no_mem_req", mem_req_valid, 0);
    end
    for (int i = 0; i <= out_dly; i++) begin
      chk("out_valid",  out_valid, 1);
      chk("out_result", out_result, e_res);
      chk("out_rd",     out_rd, rd);
      chk("out_wen",    out_wen, e_wen);
      chk("out_err",    out_err, e_err);
      chk("in_ready_done", in_ready, 0);
      mem_rsp_valid = tout && (i == 0);
      mem_rsp_rdata = $urandom;
      out_ready = (i == out_dly);
      @(negedge clk);
    end
    out_ready = 0; mem_rsp_valid = 0;
    chk("out_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 0;
    in_result = 0; in_wdata = 0; in_rd = 0; in_rd_wen = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0; out_ready = 0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_wmask", mem_req_wmask, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_err", out_err, 0);
    @(negedge clk); rst_n = 1;

    run_op(0, 1, 3'b010, 32'h80000004, 32'hDEADBEEF, 0, 5'd1, 1, 0, 0, 0);
    run_op(0, 1, 3'b000, 32'h80000003, 32'h000000AB, 0, 5'd2, 1, 1, 2, 0);
    run_op(1, 0, 3'b000, 32'h80000001, 0, 32'h123480FF, 5'd3, 1, 0, 0, 0);
    run_op(1, 0, 3'b101, 32'h80000002, 0, 32'hBEEF1234, 5'd4, 1, 0, 1, 1);
    run_op(0, 0, 3'b000, 32'h00000042, 0, 0, 5'd5, 1, 0, 0, 3);
    run_op(1, 0, 3'b010, 32'h80000010, 0, 32'h11111111, 5'd6, 1, 4, TMO, 2);
    run_op(1, 0, 3'b011, 32'h80000000, 0, 0, 5'd7, 1, 0, 0, 0);
    run_op(0, 1, 3'b100, 32'h80000000, 32'h5, 0, 5'd8, 1, 0, 0, 0);
    run_op(1, 0, 3'b010, 32'h80000002, 0, 32'hCAFEF00D, 5'd9, 1, 0, 0, 0);
    run_op(0, 1, 3'b001, 32'h80000003, 32'h0000BEEF, 0, 5'd10, 1, 0, 0, 0);

    // Reset while a request is outstanding, then while waiting for the response.
    @(negedge clk);
    in_valid = 1; in_is_load = 1; in_is_store = 0; in_funct3 = 3'b010; in_result = 32'h80000020;
    @(negedge clk);
    in_valid = 0;
    chk("pre_rst_req", mem_req_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_req_async", mem_req_valid, 0);
    chk("rst_ready_async", in_ready, 1);
    @(negedge clk); rst_n = 1;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_wait_req", mem_req_valid, 0);
    chk("rst_wait_out", out_valid, 0);
    chk("rst_wait_ready", in_ready, 1);
    @(negedge clk); rst_n = 1;
    mem_rsp_valid = 1;
    @(negedge clk);
    mem_rsp_valid = 0;
    chk("stale_rsp_idle", out_valid, 0);

    for (int k = 0; k < 300; k++) begin
      int kind, r, rsp;
      kind = $urandom_range(0, 3);
      r    = $urandom_range(0, 9);
      rsp  = (r == 9) ? TMO + $urandom_range(0, 1) : $urandom_range(0, TMO - 1);
      run_op(kind == 1, kind >= 2, 3'($urandom), 32'h80000000 | ($urandom % 32'h1000),
             $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 3), rsp,
             $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_24070016_lsu.md
Name: ysyx_24070016_lsu

Overview:
Load/store stage directly downstream of the execute stage. It takes the execute result (the effective address for memory ops, the final value otherwise), the store data and the op type, then runs a single-outstanding memory transaction. It returns a write-back packet (result, rd, write enable) to the write-back stage. Valid/ready handshakes are used on every side; one instruction is in flight at a time.

Parameters:
TIMEOUT_CYC, 255, cycles allowed in WAIT before the access aborts with error; 0 disables the timeout.
RD_W, 5, width of the destination register index.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  execute packet valid
in_ready  output  1  stage can accept a packet
in_result  input  32  execute result / effective address
in_wdata  input  32  store data (rs2)
in_funct3  input  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
in_is_load  input  1  load op
in_is_store  input  1  store op
in_rd  input  RD_W  destination register
in_rd_wen  input  1  instruction writes rd
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_req_wen  output  1  1 = write
mem_req_wdata  output  32  lane-shifted store data
mem_req_wmask  output  4  byte enables
mem_rsp_valid  input  1  response/ack valid
mem_rsp_rdata  input  32  read word
out_valid  output  1  write-back packet valid
out_ready  input  1  write-back accepts packet
out_result  output  32  value for rd
out_rd  output  RD_W  destination register
out_wen  output  1  rd write enable
out_err  output  1  access fault (illegal funct3 / timeout / misaligned)

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except in_ready=1. Reset mid-transaction abandons the access immediately; mem_req_valid falls asynchronously.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch all in_* fields.
  - Neither load nor store -> DONE. out_result=in_result, out_wen=in_rd_wen. Latency 1 cycle.
  - Load/store with illegal funct3 (011, 110, 111; 100/101 on a store) -> DONE with out_err=1, out_wen=0, out_result=0, no memory request.
  - Otherwise -> REQ.
- REQ: mem_req_valid=1. Address, wen, wdata and wmask stay stable until mem_req_ready. On the handshake -> WAIT with the timeout counter cleared.
- WAIT: mem_rsp_valid is honoured only here, at the earliest one cycle after the request handshake; it is ignored in all other states. On mem_rsp_valid -> DONE.
  - Load: lane = addr[1:0]; extract byte/half; sign-extend (b, h) or zero-extend (bu, hu); out_wen=in_rd_wen.
  - Store: out_wen=0, out_result=0.
  - Counter increments each WAIT cycle. When it reaches TIMEOUT_CYC (nonzero) -> DONE with out_err=1, out_wen=0. A later stale response is ignored.
- Store encoding:
  - sb: wmask=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - sh: wmask=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - sw: wmask=4'b1111.
  - Loads: wmask=0, wen=0.
- DONE: out_valid=1. out_* held stable until out_ready; then -> IDLE. in_ready=0 in REQ/WAIT/DONE (no overlap). A new packet is accepted the cycle after the out handshake.
- Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned; handling is set by the optional feature.

Optional Feature:
YSYX_24070016_LSU_MISALIGN_TRAP_EN
- Defined: a misaligned access goes IDLE->DONE with out_err=1, out_wen=0, and no memory request.
- Undefined: the low address bits that violate alignment are forced to 0 (h: addr[0]; w: addr[1:0]) and the access proceeds normally; out_err never set for misalignment.

Test Plan:
- sw in_result=0x80000004, in_wdata=0xDEADBEEF, mem_req_ready=1 -> mem_req_addr=0x80000004, wmask=1111, wdata=0xDEADBEEF; ack next cycle -> out_valid, out_wen=0.
- sb addr 0x80000003, wdata 0x000000AB -> addr 0x80000000, wmask=1000, wdata=0xABABABAB.
- lb addr 0x80000001, rdata 0x123480FF -> out_result 0xFFFFFF80; lhu addr 0x80000002, rdata 0xBEEF1234 -> 0x0000BEEF.
- ALU op in_result=0x42, rd=5, out_ready low 3 cycles -> out_valid held, out_result=0x42, out_rd=5 stable, in_ready=0; IDLE after the handshake.
- Load with mem_req_ready delayed 4 cycles, then no response, TIMEOUT_CYC=8 -> request stable while waiting; DONE after 8 WAIT cycles, out_err=1; late response ignored.
- rst_n low during WAIT -> mem_req_valid/out_valid 0 immediately, in_ready=1. lw at 0x80000002 -> out_err=1 if macro defined, else access at 0x80000000.
